// File: rtl/ddr_if_pkg.sv
// ddr_if_pkg: state codes and command constants shared by the DDR responder and data_cache
package ddr_if_pkg;
   typedef enum logic [3:0] {
      IDLE                 = 4'd1,
      RD_CMD               = 4'd2,
      RD_DATA              = 4'd3,
      RD_DONE              = 4'd4,
      JMP_CMD              = 4'd5,
      JMP_DATA             = 4'd6,
      WR_CMD               = 4'd8,
      MEM_WRITE_DATA_STORE = 4'd9,
      WR_DONE              = 4'd10
   } state_t;
   localparam logic CMD_RD = 1'b0;
   localparam logic CMD_WR = 1'b1;
endpackage

// File: rtl/ddr_burst_responder.sv
// ddr_burst_responder: turns cache read/store/jump requests into native-port bursts
module ddr_burst_responder
   import ddr_if_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int DDR_ADDR_WIDTH = 28,
   parameter int BURST_LEN      = 16,
   parameter int CNT_WIDTH      = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      data_read_req,
   input  logic                      data_store_req,
   input  logic                      jmp_addr_read_req,
   input  logic [DDR_ADDR_WIDTH-1:0] data_read_addr,
   input  logic [DDR_ADDR_WIDTH-1:0] data_write_addr,
   input  logic [DATA_WIDTH-1:0]     data_to_ddr,
   input  logic                      data_to_ddr_rdy,
   output logic [DATA_WIDTH-1:0]     data_to_cache,
   output logic                      rd_burst_data_valid,
   output logic [CNT_WIDTH-1:0]      rd_cnt_data,
   output logic                      wr_burst_data_req,
   output logic [DDR_ADDR_WIDTH-1:0] jmp_addr_to_cache,
   output logic [3:0]                state_interface_module,
   output logic                      mem_cmd_en,
   output logic                      mem_cmd_we,
   output logic [DDR_ADDR_WIDTH-1:0] mem_cmd_addr,
   output logic [CNT_WIDTH-1:0]      mem_cmd_len,
   input  logic                      mem_cmd_rdy,
   output logic [DATA_WIDTH-1:0]     mem_wr_data,
   output logic                      mem_wr_en,
   input  logic                      mem_wr_rdy,
   input  logic [DATA_WIDTH-1:0]     mem_rd_data,
   input  logic                      mem_rd_valid
);
   localparam logic [CNT_WIDTH-1:0] BL = CNT_WIDTH'(BURST_LEN);
   state_t state, state_n;
   logic [CNT_WIDTH-1:0] wr_cnt;
   logic rd_phase, rd_last, rd_beat, wr_xfer;
   assign rd_phase = state == RD_DATA || state == JMP_DATA;
   assign rd_last = rd_cnt_data == (state == JMP_DATA ? CNT_WIDTH'(1) : BL);
   assign rd_beat = rd_phase && !rd_last && mem_rd_valid;
   assign wr_burst_data_req = state == MEM_WRITE_DATA_STORE && mem_wr_rdy && wr_cnt < BL;
   assign wr_xfer = wr_burst_data_req && data_to_ddr_rdy;
   assign mem_wr_en = wr_xfer;
   assign mem_wr_data = wr_xfer ? data_to_ddr : '0;
   assign mem_cmd_en = state == RD_CMD || state == JMP_CMD || state == WR_CMD;
   assign mem_cmd_we = state == WR_CMD ? CMD_WR : CMD_RD;
   assign mem_cmd_len = state == JMP_CMD ? CNT_WIDTH'(1) : (state == RD_CMD || state == WR_CMD) ? BL : '0;
   assign state_interface_module = state;
   // next state: arbitration only in IDLE, bursts always run to completion
   always_comb begin
      state_n = state;
      case (state)
         IDLE:                 state_n = data_store_req ? WR_CMD : data_read_req ? RD_CMD : jmp_addr_read_req ? JMP_CMD : IDLE;
         RD_CMD:               state_n = mem_cmd_rdy ? RD_DATA : RD_CMD;
         JMP_CMD:              state_n = mem_cmd_rdy ? JMP_DATA : JMP_CMD;
         WR_CMD:               state_n = mem_cmd_rdy ? MEM_WRITE_DATA_STORE : WR_CMD;
         RD_DATA, JMP_DATA:    state_n = rd_last ? RD_DONE : state;
         MEM_WRITE_DATA_STORE: state_n = (wr_xfer && wr_cnt == BL - 1'b1) ? WR_DONE : state;
         default:              state_n = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else state <= state_n;
   end
   // datapath: latched address, registered read beats, beat counters, jump address
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_cmd_addr        <= '0;
         data_to_cache       <= '0;
         rd_burst_data_valid <= 1'b0;
         rd_cnt_data         <= '0;
         jmp_addr_to_cache   <= '0;
         wr_cnt              <= '0;
      end else begin
         if (state == IDLE && (data_store_req || data_read_req || jmp_addr_read_req))
            mem_cmd_addr <= data_store_req ? data_write_addr : data_read_addr;
         rd_burst_data_valid <= rd_beat;
         if (rd_beat) data_to_cache <= mem_rd_data;
         if (rd_beat && state == JMP_DATA) jmp_addr_to_cache <= DDR_ADDR_WIDTH'(mem_rd_data);
         rd_cnt_data <= (rd_phase && (rd_last || mem_rd_valid)) ? rd_cnt_data + 1'b1 :
                        (state == IDLE || state == RD_DONE) ? '0 : rd_cnt_data;
         wr_cnt <= state == IDLE ? '0 : wr_xfer ? wr_cnt + 1'b1 : wr_cnt;
      end
   end
endmodule

// File: tb/tb_ddr_burst_responder.sv
// tb_ddr_burst_responder: directed table-driven bench for the DDR burst responder
module tb_ddr_burst_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        data_read_req = 1'b0, data_store_req = 1'b0, jmp_addr_read_req = 1'b0;
   logic [27:0] data_read_addr = '0, data_write_addr = '0;
   logic [15:0] data_to_ddr = '0;
   logic        data_to_ddr_rdy = 1'b0;
   logic [15:0] data_to_cache;
   logic        rd_burst_data_valid;
   logic [9:0]  rd_cnt_data;
   logic        wr_burst_data_req;
   logic [27:0] jmp_addr_to_cache;
   logic [3:0]  state_interface_module;
   logic        mem_cmd_en, mem_cmd_we;
   logic [27:0] mem_cmd_addr;
   logic [9:0]  mem_cmd_len;
   logic        mem_cmd_rdy = 1'b0;
   logic [15:0] mem_wr_data;
   logic        mem_wr_en;
   logic        mem_wr_rdy = 1'b0;
   logic [15:0] mem_rd_data = '0;
   logic        mem_rd_valid = 1'b0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          is_jmp;
      logic [27:0] addr;
      logic [15:0] base;
      logic [27:0] exp_jmp;
      bit          extra;
   } vec_t;
   vec_t vecs[6];

   ddr_burst_responder dut (
      .clk(clk), .rst(rst),
      .data_read_req(data_read_req), .data_store_req(data_store_req), .jmp_addr_read_req(jmp_addr_read_req),
      .data_read_addr(data_read_addr), .data_write_addr(data_write_addr),
      .data_to_ddr(data_to_ddr), .data_to_ddr_rdy(data_to_ddr_rdy),
      .data_to_cache(data_to_cache), .rd_burst_data_valid(rd_burst_data_valid), .rd_cnt_data(rd_cnt_data),
      .wr_burst_data_req(wr_burst_data_req), .jmp_addr_to_cache(jmp_addr_to_cache),
      .state_interface_module(state_interface_module),
      .mem_cmd_en(mem_cmd_en), .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
      .mem_cmd_rdy(mem_cmd_rdy), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en), .mem_wr_rdy(mem_wr_rdy),
      .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_cmd();
      for (int i = 0; i < 20 && mem_cmd_en !== 1'b1; i++) @(negedge clk);
      chk("cmd_en", 32'(mem_cmd_en), 32'd1);
   endtask

   task automatic do_read(input logic [27:0] addr, input logic [15:0] base, input logic [27:0] exp_jmp,
                          input bit extra, input int nstop);
      data_read_req = 1'b1;
      data_read_addr = addr;
      wait_cmd();
      chk("rd_state_cmd", 32'(state_interface_module), 32'd2);
      chk("rd_cmd_we", 32'(mem_cmd_we), 32'd0);
      chk("rd_cmd_len", 32'(mem_cmd_len), 32'd16);
      chk("rd_cmd_addr", 32'(mem_cmd_addr), 32'(addr));
      mem_cmd_rdy = 1'b1;
      @(negedge clk);
      mem_cmd_rdy = 1'b0;
      data_read_req = 1'b0;
      chk("rd_cmd_drop", 32'(mem_cmd_en), 32'd0);
      chk("rd_state_data", 32'(state_interface_module), 32'd3);
      for (int k = 0; k <= 16; k++) begin
         if (k > 0) begin
            chk("rd_valid", 32'(rd_burst_data_valid), 32'd1);
            chk("rd_data", 32'(data_to_cache), 32'(base + 16'(k - 1)));
            chk("rd_cnt", 32'(rd_cnt_data), 32'(k));
            chk("rd_state", 32'(state_interface_module), 32'd3);
         end
         if (k == nstop && nstop < 16) begin
            mem_rd_valid = 1'b0;
            return;
         end
         if (k < 16) begin
            mem_rd_valid = 1'b1;
            mem_rd_data = base + 16'(k);
         end else begin
            mem_rd_valid = extra;
            mem_rd_data = 16'hDEAD;
         end
         @(negedge clk);
      end
      mem_rd_valid = 1'b0;
      chk("rd_done_cnt", 32'(rd_cnt_data), 32'd17);
      chk("rd_done_valid", 32'(rd_burst_data_valid), 32'd0);
      chk("rd_done_state", 32'(state_interface_module), 32'd4);
      chk("rd_jmp_hold", 32'(jmp_addr_to_cache), 32'(exp_jmp));
      @(negedge clk);
      chk("rd_idle_cnt", 32'(rd_cnt_data), 32'd0);
      chk("rd_idle_state", 32'(state_interface_module), 32'd1);
   endtask

   task automatic do_jmp(input logic [27:0] addr, input logic [15:0] beat, input logic [27:0] exp_jmp);
      jmp_addr_read_req = 1'b1;
      data_read_addr = addr;
      wait_cmd();
      chk("jmp_state_cmd", 32'(state_interface_module), 32'd5);
      chk("jmp_cmd_we", 32'(mem_cmd_we), 32'd0);
      chk("jmp_cmd_len", 32'(mem_cmd_len), 32'd1);
      chk("jmp_cmd_addr", 32'(mem_cmd_addr), 32'(addr));
      mem_cmd_rdy = 1'b1;
      @(negedge clk);
      mem_cmd_rdy = 1'b0;
      jmp_addr_read_req = 1'b0;
      chk("jmp_state_data", 32'(state_interface_module), 32'd6);
      mem_rd_valid = 1'b1;
      mem_rd_data = beat;
      @(negedge clk);
      chk("jmp_valid", 32'(rd_burst_data_valid), 32'd1);
      chk("jmp_cnt1", 32'(rd_cnt_data), 32'd1);
      chk("jmp_addr", 32'(jmp_addr_to_cache), 32'(exp_jmp));
      mem_rd_data = 16'hBEEF;
      @(negedge clk);
      mem_rd_valid = 1'b0;
      chk("jmp_cnt2", 32'(rd_cnt_data), 32'd2);
      chk("jmp_done_valid", 32'(rd_burst_data_valid), 32'd0);
      chk("jmp_done_state", 32'(state_interface_module), 32'd4);
      chk("jmp_extra_drop", 32'(jmp_addr_to_cache), 32'(exp_jmp));
      @(negedge clk);
      chk("jmp_idle_cnt", 32'(rd_cnt_data), 32'd0);
      chk("jmp_idle_state", 32'(state_interface_module), 32'd1);
   endtask

   task automatic do_store(input logic [27:0] addr, input bit bp);
      int idx = 0;
      data_store_req = 1'b1;
      data_write_addr = addr;
      data_to_ddr_rdy = 1'b1;
      wait_cmd();
      chk("wr_cmd_we", 32'(mem_cmd_we), 32'd1);
      chk("wr_cmd_len", 32'(mem_cmd_len), 32'd16);
      chk("wr_cmd_addr", 32'(mem_cmd_addr), 32'(addr));
      repeat (2) @(negedge clk);
      chk("wr_cmd_hold", 32'(mem_cmd_en), 32'd1);
      chk("wr_state_cmd", 32'(state_interface_module), 32'd8);
      mem_cmd_rdy = 1'b1;
      @(negedge clk);
      mem_cmd_rdy = 1'b0;
      data_store_req = 1'b0;
      chk("wr_cmd_drop", 32'(mem_cmd_en), 32'd0);
      for (int cyc = 0; cyc < 200 && state_interface_module == 4'd9; cyc++) begin
         mem_wr_rdy = bp ? (cyc % 3) != 2 : 1'b1;
         data_to_ddr_rdy = bp ? (cyc % 5) != 4 : 1'b1;
         data_to_ddr = 16'hB000 + 16'(idx);
         #1;
         chk("wr_req", 32'(wr_burst_data_req), 32'(mem_wr_rdy));
         chk("wr_en", 32'(mem_wr_en), 32'(mem_wr_rdy & data_to_ddr_rdy));
         if (mem_wr_en) begin
            chk("wr_data", 32'(mem_wr_data), 32'(16'hB000 + 16'(idx)));
            idx++;
         end
         @(negedge clk);
      end
      mem_wr_rdy = 1'b1;
      #1;
      chk("wr_beats", 32'(idx), 32'd16);
      chk("wr_done_state", 32'(state_interface_module), 32'd10);
      chk("wr_done_noreq", 32'(wr_burst_data_req), 32'd0);
      @(negedge clk);
      chk("wr_idle_state", 32'(state_interface_module), 32'd1);
      mem_wr_rdy = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b0, 28'h0000400, 16'hA000, 28'h0000000, 1'b0};
      vecs[1] = '{1'b1, 28'h0000040, 16'h1234, 28'h0001234, 1'b0};
      vecs[2] = '{1'b0, 28'h0000123, 16'h5550, 28'h0001234, 1'b1};
      vecs[3] = '{1'b0, 28'hFFFFFFF, 16'hFFF0, 28'h0001234, 1'b0};
      vecs[4] = '{1'b1, 28'h0000000, 16'hFFFF, 28'h000FFFF, 1'b0};
      vecs[5] = '{1'b0, 28'h0ABCDEF, 16'h0100, 28'h000FFFF, 1'b1};
      repeat (2) @(negedge clk);
      chk("rst_state", 32'(state_interface_module), 32'd1);
      chk("rst_outs", 32'({mem_cmd_en, mem_cmd_we, rd_burst_data_valid, wr_burst_data_req, mem_wr_en}), 32'd0);
      chk("rst_cnt", 32'(rd_cnt_data), 32'd0);
      chk("rst_jmp", 32'(jmp_addr_to_cache), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_state", 32'(state_interface_module), 32'd1);
      mem_rd_valid = 1'b1;
      mem_rd_data = 16'h7777;
      @(negedge clk);
      mem_rd_valid = 1'b0;
      chk("idle_rd_ignored", 32'({rd_burst_data_valid, 10'(rd_cnt_data)}), 32'd0);
      for (int i = 0; i < 6; i++)
         if (vecs[i].is_jmp) do_jmp(vecs[i].addr, vecs[i].base, vecs[i].exp_jmp);
         else do_read(vecs[i].addr, vecs[i].base, vecs[i].exp_jmp, vecs[i].extra, 16);
      do_store(28'h0000800, 1'b1);
      data_read_req = 1'b1;
      data_read_addr = 28'h0000300;
      do_store(28'h0000900, 1'b0);
      @(negedge clk);
      chk("simul_rd_follows", 32'(state_interface_module), 32'd2);
      do_read(28'h0000300, 16'h7700, 28'h000FFFF, 1'b0, 16);
      do_read(28'h0000500, 16'hC000, 28'h000FFFF, 1'b0, 5);
      rst = 1'b0;
      #1;
      chk("mid_rst_state", 32'(state_interface_module), 32'd1);
      chk("mid_rst_cnt", 32'(rd_cnt_data), 32'd0);
      chk("mid_rst_valid", 32'(rd_burst_data_valid), 32'd0);
      chk("mid_rst_data", 32'(data_to_cache), 32'd0);
      chk("mid_rst_cmd", 32'({mem_cmd_en, mem_cmd_we, 10'(mem_cmd_len)}), 32'd0);
      chk("mid_rst_addr", 32'(mem_cmd_addr), 32'd0);
      chk("mid_rst_jmp", 32'(jmp_addr_to_cache), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_read(28'h0000600, 16'hD000, 28'h0000000, 1'b0, 16);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ddr_burst_responder.md
Name: ddr_burst_responder

Overview:
- DDR-side responder for the data/instruction caches. Accepts level-sensitive read, store and jump-address requests from data_cache. Converts each into one burst on a simple memory-controller native port.
- Streams read beats back to the cache with a beat counter. Pulls store beats from the cache with a per-beat request.
- Exports its state code so the cache can qualify write-data requests.

Parameters:
- DATA_WIDTH, 16, width of one data beat on both sides
- DDR_ADDR_WIDTH, 28, memory address width
- BURST_LEN, 16, beats per data read/store burst; must equal the cache depth
- CNT_WIDTH, 10, width of rd_cnt_data

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- data_read_req  in  1  cache requests a BURST_LEN read
- data_store_req  in  1  cache requests a BURST_LEN write
- jmp_addr_read_req  in  1  cache requests a 1-beat jump-address read
- data_read_addr  in  DDR_ADDR_WIDTH  read burst base address
- data_write_addr  in  DDR_ADDR_WIDTH  write burst base address
- data_to_ddr  in  DATA_WIDTH  store beat from cache
- data_to_ddr_rdy  in  1  data_to_ddr valid
- data_to_cache  out  DATA_WIDTH  read beat to cache
- rd_burst_data_valid  out  1  data_to_cache valid this cycle
- rd_cnt_data  out  CNT_WIDTH  read beat counter
- wr_burst_data_req  out  1  responder wants a store beat this cycle
- jmp_addr_to_cache  out  DDR_ADDR_WIDTH  captured jump address
- state_interface_module  out  4  current state code
- mem_cmd_en  out  1  command valid
- mem_cmd_we  out  1  1 = write, 0 = read
- mem_cmd_addr  out  DDR_ADDR_WIDTH  command address
- mem_cmd_len  out  CNT_WIDTH  beats in command
- mem_cmd_rdy  in  1  controller accepts command
- mem_wr_data  out  DATA_WIDTH  write beat
- mem_wr_en  out  1  write beat valid
- mem_wr_rdy  in  1  controller can take a write beat
- mem_rd_data  in  DATA_WIDTH  read beat
- mem_rd_valid  in  1  read beat valid

Behaviour:
- Reset (async, rst=0):
  - state IDLE.
  - All outputs 0, except state_interface_module = IDLE code.
  - jmp_addr_to_cache is cleared.
  - Any burst in flight is abandoned; the controller side is not drained.
- State codes, 4 bits, in the package:
  - IDLE=1, RD_CMD=2, RD_DATA=3, RD_DONE=4, JMP_CMD=5, JMP_DATA=6
  - WR_CMD=8, MEM_WRITE_DATA_STORE=9, WR_DONE=10
  - state_interface_module is registered and equals the current state.
- IDLE:
  - Arbitration is sampled only in IDLE. Priority: store > read > jump.
  - The selected address is latched into mem_cmd_addr. Read/write beat counters are cleared.
- RD_CMD / JMP_CMD / WR_CMD:
  - mem_cmd_en=1; mem_cmd_we=1 only in WR_CMD.
  - mem_cmd_len = BURST_LEN for data commands, 1 for jump.
  - Leave on the cycle mem_cmd_en & mem_cmd_rdy; mem_cmd_en drops the following cycle.
  - Next state: RD_DATA, JMP_DATA or MEM_WRITE_DATA_STORE respectively.
- RD_DATA:
  - Each mem_rd_valid cycle drives data_to_cache, asserts rd_burst_data_valid and increments rd_cnt_data. All three are registered, one cycle after the mem beat.
  - The first beat shows rd_cnt_data=1; the last shows BURST_LEN.
  - After the last beat, go to RD_DONE.
- RD_DONE:
  - Lasts one cycle. rd_cnt_data = BURST_LEN+1, rd_burst_data_valid=0.
  - Then IDLE, where rd_cnt_data returns to 0.
- JMP_DATA:
  - The single beat is zero-extended into jmp_addr_to_cache, which holds until the next jump read or reset.
  - rd_burst_data_valid=1 and rd_cnt_data=1 for that one cycle.
  - Then RD_DONE, with rd_cnt_data=2.
- MEM_WRITE_DATA_STORE:
  - wr_burst_data_req = mem_wr_rdy & (wr_cnt < BURST_LEN), combinational.
  - A beat is transferred when wr_burst_data_req & data_to_ddr_rdy. On that cycle mem_wr_en=1, mem_wr_data=data_to_ddr, wr_cnt increments.
  - A cycle with no transfer does not advance the count.
  - After beat BURST_LEN, go to WR_DONE.
- WR_DONE: one cycle, then IDLE.
- Request deassertion mid-burst does not abort the burst. The burst always completes.
- A request still asserted on return to IDLE starts a new burst. The minimum gap between bursts is one IDLE cycle.
- mem_rd_valid outside RD_DATA/JMP_DATA is ignored.
- Beats beyond the expected count are dropped.
- Addresses pass through unchanged; byte scaling is done by the cache.

Decomposition:
- Package ddr_if_pkg holds:
  - the state codes above;
  - the command constants CMD_RD=0 and CMD_WR=1.
  - data_cache imports MEM_WRITE_DATA_STORE from this package.
- No sub-module is required. The beat counter is inline.

Test Plan:
- Read burst: data_read_req=1, addr=0x0000400, controller returns beats 0xA000..0xA00F.
  -> One command with we=0, len=16.
  -> rd_cnt_data steps 1..16 with data 0xA000..0xA00F, then 17 for one cycle, then 0.
- Store with backpressure: data_store_req=1, addr=0x0000800, cache supplies 0xB000+i, mem_wr_rdy low every third cycle.
  -> Exactly 16 mem_wr_en beats, in order.
  -> State code is 9 throughout data, then 10, then 1.
- Simultaneous requests: read and store asserted in the same IDLE cycle -> write burst first; read burst follows after one IDLE cycle.
- Jump read: jmp_addr_read_req=1, beat 0x1234.
  -> jmp_addr_to_cache = 0x0001234, valid with rd_cnt_data=1, then 2, then 0.
  -> Value holds through a subsequent data read.
- Reset mid-read: rst low after beat 5.
  -> All outputs 0 and state code 1 immediately.
  -> After release, a new read burst completes normally with rd_cnt_data 1..16.
